lbp_scan_ctrl: RTL and testbench

Sequencer for the LBP engine on a W×H 8-bit grayscale image in raster order.
Walks every interior pixel, fetches its 3×3 neighbourhood from gray memory over the gray_req/gray_ready port, and reuses two columns when stepping right.
Hands each window to the combinational/pipelined LBP compute unit by valid/ready, then writes the returned code to LBP memory at the centre address.
Raises finish when the whole image is done.

---
 rtl/lbp_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lbp_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl: raster-order sequencer for the LBP engine.
// Walks every interior pixel of a W x H grayscale image, gathers its 3x3
// neighbourhood from gray memory (full fill at the start of a row, one new
// column per step right), hands the window to the LBP compute unit and writes
// the returned code back to LBP memory at the centre address.
// Build option: define BORDER_WRITE_EN to also zero every border pixel of the
// LBP image after the last interior write.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for gray memory to become available
// S_FILL     | nine column-major reads for the first window of a row
// S_SHIFT    | three reads of the new right-hand column
// S_ISSUE    | window presented to compute unit, waiting for win_ready
// S_WAIT_RES | window accepted, waiting for res_valid
// S_WRITE    | one-cycle LBP write at the centre address, position advance
// S_BORDER   | zero writes to border pixels (BORDER_WRITE_EN builds only)
// S_DONE     | image complete, finish held until reset

module lbp_scan_ctrl #(
   parameter int W  = 128,
   parameter int H  = 128,
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gray_ready,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   input  logic [7:0]    gray_data,
   output logic          win_valid,
   input  logic          win_ready,
   output logic [71:0]   win_data,
   input  logic          res_valid,
   input  logic [7:0]    res_code,
   output logic          lbp_valid,
   output logic [AW-1:0] lbp_addr,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_SHIFT,
      S_ISSUE,
      S_WAIT_RES,
      S_WRITE,
      S_BORDER,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] W_A    = AW'(W);
   localparam logic [AW-1:0] C_LAST = AW'(W - 2);
   localparam logic [AW-1:0] R_LAST = AW'(H - 2);

   state_t          state, state_nxt;
   logic [AW-1:0]   r, c;
   logic [1:0]      rd_row, rd_col;
   logic [7:0]      pix [9];
   logic [7:0]      code_q;

   logic            rd_fire;
   logic            rd_last;
   logic [3:0]      rd_idx;
   logic [AW-1:0]   rd_r, rd_c, rd_addr, ctr_addr;
   logic            last_pix;

`ifdef BORDER_WRITE_EN
   localparam logic [AW-1:0] BR_LAST = AW'(H - 1);
   localparam logic [AW-1:0] BC_LAST = AW'(W - 1);
   logic [AW-1:0]   br, bc;
`endif

   // read-side address and window-slot decode for the current fetch
   always_comb begin
      rd_fire  = gray_req & gray_ready;
      rd_last  = (rd_row == 2'd2) && ((state == S_SHIFT) || (rd_col == 2'd2));
      rd_idx   = ({2'b00, rd_row} * 4'd3) + {2'b00, rd_col};
      rd_r     = r - AW'(1) + AW'(rd_row);
      rd_c     = c - AW'(1) + AW'(rd_col);
      rd_addr  = (rd_r * W_A) + rd_c;
      ctr_addr = (r * W_A) + c;
      last_pix = (r == R_LAST) && (c == C_LAST);
      win_data = '0;
      for (int i = 0; i < 9; i++) begin
         win_data[i*8 +: 8] = pix[i];
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state and output decode
   always_comb begin
      state_nxt = state;
      gray_req  = 1'b0;
      gray_addr = '0;
      win_valid = 1'b0;
      lbp_valid = 1'b0;
      lbp_addr  = '0;
      lbp_data  = '0;
      finish    = 1'b0;
      case (state)
         S_IDLE: begin
            if (gray_ready) state_nxt = S_FILL;
         end
         S_FILL, S_SHIFT: begin
            gray_req  = gray_ready;
            gray_addr = rd_addr;
            if (rd_fire && rd_last) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            win_valid = 1'b1;
            if (win_ready) state_nxt = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            if (res_valid) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            lbp_valid = 1'b1;
            lbp_addr  = ctr_addr;
            lbp_data  = code_q;
            if (last_pix) begin
`ifdef BORDER_WRITE_EN
               state_nxt = S_BORDER;
`else
               state_nxt = S_DONE;
`endif
            end else if (c == C_LAST) begin
               state_nxt = S_FILL;
            end else begin
               state_nxt = S_SHIFT;
            end
         end
`ifdef BORDER_WRITE_EN
         S_BORDER: begin
            lbp_valid = 1'b1;
            lbp_addr  = (br * W_A) + bc;
            lbp_data  = 8'h00;
            if ((br == BR_LAST) && (bc == BC_LAST)) state_nxt = S_DONE;
         end
`endif
         S_DONE: begin
            finish = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // position, read counters, window slots and captured result code
   always_ff @(posedge clk) begin
      if (reset) begin
         r      <= AW'(1);
         c      <= AW'(1);
         rd_row <= 2'd0;
         rd_col <= 2'd0;
         code_q <= 8'h00;
         for (int i = 0; i < 9; i++) pix[i] <= 8'h00;
`ifdef BORDER_WRITE_EN
         br     <= '0;
         bc     <= '0;
`endif
      end else begin
         if (rd_fire) begin
            pix[rd_idx] <= gray_data;
            if (rd_row == 2'd2) begin
               rd_row <= 2'd0;
               if (state == S_FILL) rd_col <= rd_col + 2'd1;
            end else begin
               rd_row <= rd_row + 2'd1;
            end
         end
         if ((state == S_WAIT_RES) && res_valid) code_q <= res_code;
         if (state == S_WRITE) begin
            rd_row <= 2'd0;
            if (c == C_LAST) begin
               c      <= AW'(1);
               r      <= r + AW'(1);
               rd_col <= 2'd0;
            end else begin
               // step right: keep the two right-hand columns, refetch the third
               c      <= c + AW'(1);
               rd_col <= 2'd2;
               pix[0] <= pix[1];
               pix[1] <= pix[2];
               pix[3] <= pix[4];
               pix[4] <= pix[5];
               pix[6] <= pix[7];
               pix[7] <= pix[8];
            end
         end
`ifdef BORDER_WRITE_EN
         if (state == S_BORDER) begin
            if (bc == BC_LAST) begin
               bc <= '0;
               br <= br + AW'(1);
            end else if ((br == '0) || (br == BR_LAST)) begin
               bc <= bc + AW'(1);
            end else begin
               bc <= BC_LAST;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Self-checking bench for lbp_scan_ctrl on a small random image.
// The bench plays gray memory (combinational read of img[]) and the LBP
// compute unit (code from the accepted window, random latency), and checks
// read addresses, windows, writes and finish against a model built from the
// image and the raster-scan rules.
module tb_lbp_scan_ctrl;
   localparam int W     = 7;
   localparam int H     = 5;
   localparam int AW    = 6;
   localparam int NPIX  = W * H;
   localparam int NINT  = (W - 2) * (H - 2);
   localparam int NRD   = (H - 2) * (9 + 3 * (W - 3));
   localparam int LIMIT = 5000;

   logic          clk = 1'b0;
   logic          reset;
   logic          gray_ready, gray_req, win_valid, win_ready, res_valid, lbp_valid, finish;
   logic [AW-1:0] gray_addr, lbp_addr;
   logic [7:0]    gray_data, res_code, lbp_data;
   logic [71:0]   win_data;
   logic [7:0]    img [64];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   always_comb gray_data = img[gray_addr];

   lbp_scan_ctrl #(.W(W), .H(H), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .gray_ready (gray_ready),
      .gray_req   (gray_req),
      .gray_addr  (gray_addr),
      .gray_data  (gray_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .res_valid  (res_valid),
      .res_code   (res_code),
      .lbp_valid  (lbp_valid),
      .lbp_addr   (lbp_addr),
      .lbp_data   (lbp_data),
      .finish     (finish)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // LBP code: neighbours p0..p3,p5..p8 in order, bit set when >= centre
   function automatic logic [7:0] lbp72(input logic [71:0] w);
      logic [7:0] ctr;
      int k;
      ctr = w[39:32];
      k = 0;
      lbp72 = 8'h00;
      for (int i = 0; i < 9; i++) begin
         if (i != 4) begin
            lbp72[k] = (w[i*8 +: 8] >= ctr);
            k++;
         end
      end
   endfunction

   function automatic logic [71:0] win_at(input int r, input int c);
      win_at = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            win_at[(i*3+j)*8 +: 8] = img[(r-1+i)*W + (c-1+j)];
   endfunction

   function automatic logic [127:0] all_outs();
      all_outs = {gray_req, gray_addr, win_valid, win_data, lbp_valid, lbp_addr, lbp_data, finish};
   endfunction

   // mode 0: always ready, 1-cycle compute; mode 1: random handshakes;
   // mode 2: 3-cycle gray stall after read 4 and 10-cycle win_ready hold.
   // abort_hs > 0: reset during WAIT_RES of that window and return.
   task automatic run_image(input int mode, input int abort_hs, input bit do_reset);
      int rd_q[$];
      int wa_q[$];
      int wd_q[$];
      int rd_i, wr_i, hs, res_cnt, hold_left, stall_left, last_wr_cyc, post;
      bit waiting, holding, fin_due;
      logic [71:0] held;
      logic [7:0]  pend;

      rd_i = 0; wr_i = 0; hs = 0; res_cnt = 0; post = 0; last_wr_cyc = 0;
      waiting = 0; holding = 0; fin_due = 0; held = '0; pend = '0;
      hold_left  = (mode == 2) ? 10 : 0;
      stall_left = (mode == 2) ? 3 : 0;

      for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
      for (int r = 1; r <= H - 2; r++)
         for (int c = 1; c <= W - 2; c++) begin
            if (c == 1) begin
               for (int col = 0; col < 3; col++)
                  for (int row = 0; row < 3; row++)
                     rd_q.push_back((r - 1 + row) * W + (c - 1 + col));
            end else begin
               for (int row = 0; row < 3; row++)
                  rd_q.push_back((r - 1 + row) * W + c + 1);
            end
            wa_q.push_back(r * W + c);
            wd_q.push_back(int'(lbp72(win_at(r, c))));
         end
`ifdef BORDER_WRITE_EN
      for (int a = 0; a < NPIX; a++)
         if (a < W || a >= NPIX - W || (a % W) == 0 || (a % W) == W - 1) begin
            wa_q.push_back(a);
            wd_q.push_back(0);
         end
`endif

      gray_ready = 1'b0; win_ready = 1'b0; res_valid = 1'b0; res_code = 8'h00;
      if (do_reset) begin
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
      end
      chk("reset_outputs", all_outs(), '0);

      for (int cyc = 0; cyc < LIMIT; cyc++) begin
         res_valid = 1'b0;
         res_code  = 8'($urandom);
         if (waiting) begin
            res_cnt--;
            if (res_cnt == 0) begin
               res_valid = 1'b1;
               res_code  = pend;
               waiting   = 0;
            end
         end else if (mode == 1 && $urandom_range(3) == 0) begin
            res_valid = 1'b1;
         end
         case (mode)
            0: begin gray_ready = 1'b1; win_ready = 1'b1; end
            1: begin
               gray_ready = ($urandom_range(3) != 0);
               win_ready  = ($urandom_range(1) == 1);
            end
            default: begin
               gray_ready = 1'b1;
               if (rd_i == 4 && stall_left > 0) begin
                  gray_ready = 1'b0;
                  stall_left--;
               end
               win_ready = 1'b1;
               if (win_valid && hs == 1 && hold_left > 0) begin
                  win_ready = 1'b0;
                  hold_left--;
               end
            end
         endcase
         #1;
         if (fin_due) begin
            chk("finish_held", finish, 1);
            chk("done_quiet", {gray_req, win_valid, lbp_valid}, 0);
            post++;
            if (post == 4) begin
               chk("read_count", rd_i, NRD);
               chk("write_count", wr_i, wa_q.size());
               return;
            end
         end else begin
            chk("finish_early", finish, 0);
            if (!gray_ready) chk("req_during_stall", gray_req, 0);
            if (gray_req && gray_ready) begin
               chk("rd_addr", gray_addr, (rd_i < rd_q.size()) ? rd_q[rd_i] : -1);
               rd_i++;
            end
            if (win_valid) begin
               chk("no_read_while_issue", gray_req, 0);
               if (holding) chk("win_stable", win_data, held);
               held    = win_data;
               holding = 1;
               if (win_ready) begin
                  chk("window", win_data, win_at(1 + hs / (W - 2), 1 + hs % (W - 2)));
                  pend    = lbp72(win_data);
                  res_cnt = (mode == 0) ? 1 : $urandom_range(1, 4);
                  waiting = 1;
                  holding = 0;
                  hs++;
                  if (abort_hs != 0 && hs == abort_hs) begin
                     @(posedge clk); #1;
                     reset = 1'b1; res_valid = 1'b0; gray_ready = 1'b0; win_ready = 1'b0;
                     @(posedge clk); #1;
                     chk("abort_reset_outputs", all_outs(), '0);
                     chk("abort_no_write", wr_i, abort_hs - 1);
                     reset = 1'b0;
                     return;
                  end
               end
            end
            if (lbp_valid) begin
               if (wr_i < wa_q.size()) begin
                  chk("lbp_addr", lbp_addr, wa_q[wr_i]);
                  chk("lbp_data", lbp_data, wd_q[wr_i]);
                  if (mode == 0 && wr_i > 0 && wr_i < NINT && (wr_i % (W - 2)) != 0)
                     chk("shift_window_cycles", cyc - last_wr_cyc, 6);
                  if (wr_i >= NINT) chk("border_back_to_back", cyc - last_wr_cyc, 1);
               end else begin
                  checks++;
                  errors++;
                  $error("FAIL extra_write observed addr=%0d expected no write", lbp_addr);
               end
               last_wr_cyc = cyc;
               wr_i++;
               if (wr_i == wa_q.size()) fin_due = 1;
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      errors++;
      $error("FAIL timeout observed writes=%0d expected writes=%0d", wr_i, wa_q.size());
   endtask

   initial begin
      reset = 1'b1;
      gray_ready = 1'b0; win_ready = 1'b0; res_valid = 1'b0; res_code = 8'h00;
      @(posedge clk); #1;
      run_image(0, 0, 1'b1);
      run_image(0, 3, 1'b1);
      run_image(0, 0, 1'b0);
      run_image(2, 0, 1'b1);
      for (int n = 0; n < 4; n++) run_image(1, 0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
